ntt_bf_sched: RTL and testbench

Stage scheduler that drives one pipelined NTT/INTT butterfly from the feeding side and collects its results. It walks all radix-2 stages of an N-point transform and issues coefficient-RAM read addresses and twiddle-ROM addresses at one butterfly per cycle. It writes results back in place after the butterfly's fixed latency and drains the pipeline between stages to avoid read-after-write hazards. Data paths run RAM to butterfly u/t, ROM to w, and s0/s1 to RAM; this block handles control and addresses only.

---
 rtl/ntt_bf_sched.sv | 157 +++++++++++++++
 tb/tb_ntt_bf_sched.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_bf_sched.sv
// Stage scheduler for one pipelined NTT/INTT butterfly: walks every radix-2 stage,
// issues RAM/ROM read addresses one pair per cycle and replays them as in-place writes.
module ntt_bf_sched #(
    parameter int N      = 256,
    parameter int LOGN   = 8,
    parameter int BF_LAT = 14,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            mode,
    output logic            busy,
    output logic            done,
    output logic            rd_en,
    output logic [LOGN-1:0] rd_addr0,
    output logic [LOGN-1:0] rd_addr1,
    output logic [LOGN-1:0] tw_addr,
    output logic            bf_sel,
    output logic            wr_en,
    output logic [LOGN-1:0] wr_addr0,
    output logic [LOGN-1:0] wr_addr1
);

    localparam int DLAT = RD_LAT + BF_LAT;
    localparam int DCW  = $clog2(DLAT + 1);
    localparam logic [LOGN-1:0] HALF       = LOGN'(N / 2);
    localparam logic [LOGN-1:0] LAST_PAIR  = LOGN'(N / 2 - 1);
    localparam logic [LOGN-1:0] K_LAST     = LOGN'(N - 1);
    localparam logic [DCW-1:0]  DRAIN_LAST = DCW'(DLAT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    state_t          state, state_nxt;
    logic            mode_q;
    logic [LOGN-1:0] len, base, off, k, issue_cnt;
    logic [DCW-1:0]  drain_cnt;
    logic            pair_last, group_last, drain_last, stage_last;

    logic [DLAT-1:0] v_pipe;
    logic [LOGN-1:0] a0_pipe [DLAT];
    logic [LOGN-1:0] a1_pipe [DLAT];

    always_comb begin
        pair_last  = (issue_cnt == LAST_PAIR);
        group_last = (off == len - LOGN'(1));
        drain_last = (drain_cnt == DRAIN_LAST);
        stage_last = mode_q ? (len == LOGN'(1)) : (len == HALF);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // start is a bare request with no ready: it is honoured only in IDLE and
    // silently dropped in every other state, including FIN.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        rd_en     = 1'b0;
        rd_addr0  = '0;
        rd_addr1  = '0;
        tw_addr   = '0;
        bf_sel    = (state != IDLE) ? mode_q : 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = ISSUE;
            end
            ISSUE: begin
                busy     = 1'b1;
                rd_en    = 1'b1;
                rd_addr0 = base + off;
                rd_addr1 = base + off + len;
                tw_addr  = k;
                if (pair_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_last) state_nxt = stage_last ? FIN : ISSUE;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // k runs continuously across stages, so only the in-stage counters rewind.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= 1'b0;
            len       <= '0;
            base      <= '0;
            off       <= '0;
            k         <= '0;
            issue_cnt <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q    <= mode;
                        len       <= mode ? HALF : LOGN'(1);
                        k         <= mode ? LOGN'(1) : K_LAST;
                        base      <= '0;
                        off       <= '0;
                        issue_cnt <= '0;
                        drain_cnt <= '0;
                    end
                end
                ISSUE: begin
                    issue_cnt <= pair_last ? '0 : issue_cnt + LOGN'(1);
                    if (group_last) begin
                        off  <= '0;
                        base <= pair_last ? '0 : base + (len << 1);
                        k    <= mode_q ? k + LOGN'(1) : k - LOGN'(1);
                    end else begin
                        off <= off + LOGN'(1);
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_last ? '0 : drain_cnt + DCW'(1);
                    if (drain_last && !stage_last)
                        len <= mode_q ? (len >> 1) : (len << 1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_pipe <= '0;
            for (int i = 0; i < DLAT; i++) begin
                a0_pipe[i] <= '0;
                a1_pipe[i] <= '0;
            end
        end else begin
            v_pipe[0]  <= rd_en;
            a0_pipe[0] <= rd_addr0;
            a1_pipe[0] <= rd_addr1;
            for (int i = 1; i < DLAT; i++) begin
                v_pipe[i]  <= v_pipe[i-1];
                a0_pipe[i] <= a0_pipe[i-1];
                a1_pipe[i] <= a1_pipe[i-1];
            end
        end
    end

    assign wr_en    = v_pipe[DLAT-1];
    assign wr_addr0 = a0_pipe[DLAT-1];
    assign wr_addr1 = a1_pipe[DLAT-1];

endmodule

// File: tb/tb_ntt_bf_sched.sv
// Bench for ntt_bf_sched (N=8): loop-nest reference for issue order and timing,
// plus a RAM/butterfly model whose final contents must equal the textbook transform.
module tb_ntt_bf_sched;

    localparam int N      = 8;
    localparam int LOGN   = 3;
    localparam int BF_LAT = 14;
    localparam int RD_LAT = 1;
    localparam int D      = RD_LAT + BF_LAT;
    localparam int HALF   = N / 2;
    localparam int T_DONE = 1 + LOGN * (HALF + D);
    localparam int Q      = 7681;

    logic            clk = 1'b0;
    logic            rst, start, mode;
    logic            busy, done, rd_en, bf_sel, wr_en;
    logic [LOGN-1:0] rd_addr0, rd_addr1, tw_addr, wr_addr0, wr_addr1;

    always #5 clk = ~clk;

    ntt_bf_sched #(.N(N), .LOGN(LOGN), .BF_LAT(BF_LAT), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .busy(busy), .done(done), .rd_en(rd_en),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .tw_addr(tw_addr),
        .bf_sel(bf_sel), .wr_en(wr_en), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1)
    );

    typedef struct packed {
        logic [15:0]     cyc;
        logic [LOGN-1:0] a0, a1, k;
    } iss_t;
    typedef struct packed {
        logic [15:0]     cyc;
        logic [LOGN-1:0] a0, a1;
    } wr_t;

    iss_t        exp_iss_q[$];
    wr_t         exp_wr_q[$];
    logic [31:0] res_q[$];
    int unsigned ram[N], gold[N], tw_rom[N];
    int          wr_count;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned mulq(input int unsigned a, input int unsigned b);
        return (a * b) % Q;
    endfunction

    function automatic void bfly(input logic m, input int unsigned u, input int unsigned t,
                                 input int unsigned w, output int unsigned s0, output int unsigned s1);
        int unsigned wt;
        if (m) begin
            wt = mulq(w, t);
            s0 = (u + wt) % Q;
            s1 = (u + Q - wt) % Q;
        end else begin
            s0 = (u + t) % Q;
            s1 = mulq((u + Q - t) % Q, w);
        end
    endfunction

    // Textbook loop nest: yields the expected issue list and the golden result.
    function automatic void build_model(input logic m);
        int k   = m ? 1 : N - 1;
        int len = m ? HALF : 1;
        int unsigned s0, s1;
        exp_iss_q.delete();
        gold = ram;
        for (int s = 0; s < LOGN; s++) begin
            int p = 0;
            for (int base = 0; base < N; base += 2 * len) begin
                for (int j = base; j < base + len; j++) begin
                    iss_t e;
                    e.cyc = 16'(1 + s * (HALF + D) + p);
                    e.a0  = LOGN'(j);
                    e.a1  = LOGN'(j + len);
                    e.k   = LOGN'(k);
                    exp_iss_q.push_back(e);
                    bfly(m, gold[j], gold[j+len], tw_rom[k], s0, s1);
                    gold[j]     = s0;
                    gold[j+len] = s1;
                    p++;
                end
                k = m ? k + 1 : k - 1;
            end
            len = m ? len / 2 : len * 2;
        end
    endfunction

    task automatic sample(input int rel, input logic m, input bit live);
        logic exp_busy, exp_done, exp_sel, exp_rd, exp_wr;
        int unsigned s0, s1;
        iss_t e;
        wr_t  w;
        exp_busy = live && rel >= 1 && rel < T_DONE;
        exp_done = live && rel == T_DONE;
        exp_sel  = (live && rel >= 1 && rel <= T_DONE) ? m : 1'b0;
        exp_rd   = exp_iss_q.size() > 0 && int'(exp_iss_q[0].cyc) == rel;
        exp_wr   = exp_wr_q.size() > 0 && int'(exp_wr_q[0].cyc) == rel;
        check($sformatf("busy@%0d", rel), busy, exp_busy);
        check($sformatf("done@%0d", rel), done, exp_done);
        check($sformatf("bf_sel@%0d", rel), bf_sel, exp_sel);
        check($sformatf("rd_en@%0d", rel), rd_en, exp_rd);
        check($sformatf("wr_en@%0d", rel), wr_en, exp_wr);
        if (rd_en && wr_en)
            check($sformatf("raw_hazard@%0d", rel),
                  (rd_addr0 == wr_addr0) || (rd_addr0 == wr_addr1) ||
                  (rd_addr1 == wr_addr0) || (rd_addr1 == wr_addr1), 0);
        if (exp_rd) begin
            e = exp_iss_q.pop_front();
            check($sformatf("rd_addr0@%0d", rel), rd_addr0, e.a0);
            check($sformatf("rd_addr1@%0d", rel), rd_addr1, e.a1);
            check($sformatf("tw_addr@%0d", rel), tw_addr, e.k);
            w.cyc = 16'(rel + D);
            w.a0  = e.a0;
            w.a1  = e.a1;
            exp_wr_q.push_back(w);
        end
        if (exp_wr) begin
            w = exp_wr_q.pop_front();
            check($sformatf("wr_addr0@%0d", rel), wr_addr0, w.a0);
            check($sformatf("wr_addr1@%0d", rel), wr_addr1, w.a1);
        end
        // RAM model: reads see all writes from earlier cycles, not this one.
        if (rd_en) begin
            bfly(bf_sel, ram[rd_addr0], ram[rd_addr1], tw_rom[tw_addr], s0, s1);
            res_q.push_back({s0[15:0], s1[15:0]});
        end
        if (wr_en) begin
            wr_count++;
            check($sformatf("wr_data_avail@%0d", rel), res_q.size() > 0, 1);
            if (res_q.size() > 0) begin
                logic [31:0] r;
                r = res_q.pop_front();
                ram[wr_addr0] = {16'd0, r[31:16]};
                ram[wr_addr1] = {16'd0, r[15:0]};
            end
        end
    endtask

    task automatic run(input logic m, input bit noise, input int abort_at);
        for (int i = 0; i < N; i++) ram[i] = $urandom_range(0, Q - 1);
        build_model(m);
        exp_wr_q.delete();
        res_q.delete();
        wr_count = 0;
        @(posedge clk); #1;
        start = 1'b1;
        mode  = m;
        @(negedge clk);
        sample(0, m, 1);
        for (int rel = 1; rel <= T_DONE + 2; rel++) begin
            @(posedge clk); #1;
            start = noise && (rel == 5 || rel == 30 || rel == T_DONE);
            mode  = noise ? ~mode : m;
            rst   = (abort_at != 0 && rel == abort_at);
            @(negedge clk);
            if (abort_at != 0 && rel > abort_at) begin
                if (rel == abort_at + 1) begin
                    exp_iss_q.delete();
                    exp_wr_q.delete();
                    res_q.delete();
                end
                sample(rel, m, 0);
                if (rel >= abort_at + 21) break;
            end else begin
                sample(rel, m, 1);
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
        mode  = 1'b0;
        rst   = 1'b0;
        if (abort_at == 0) begin
            check("issues_left", exp_iss_q.size(), 0);
            check("writes_left", exp_wr_q.size(), 0);
            check("wr_count", wr_count, LOGN * HALF);
            for (int i = 0; i < N; i++)
                check($sformatf("ram[%0d]", i), ram[i], gold[i]);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        for (int i = 0; i < N; i++) tw_rom[i] = $urandom_range(1, Q - 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_addrs", {rd_addr0, rd_addr1, tw_addr, wr_addr0, wr_addr1}, 0);
        check("rst_bf_sel", bf_sel, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run(1'b1, 1'b0, 0);
        run(1'b0, 1'b0, 0);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        run(1'b1, 1'b1, 0);
        run(1'b0, 1'b1, 0);
        run(1'b1, 1'b0, 10);
        run(1'b1, 1'b0, 0);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        run(1'b0, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
